// File: rtl/parity_checker_rx.sv
// parity_checker_rx
//   Serial receiver and parity checker for frames produced by parity_generator.
//   Frame: start (0), DATA_W data bits LSB first, parity bit, stop (1).
//   Each bit lasts CLKS_PER_BIT clocks. Start is verified at mid-bit, and every
//   later bit is sampled one full bit period after the previous sample.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   s_in       in   serial line, idle high
//   d_out      out  [DATA_W-1:0] last received data word
//   valid      out  one-cycle strobe when d_out and the flags update
//   parity_err out  parity mismatch for the frame in d_out
//   frame_err  out  stop bit sampled 0 for the frame in d_out
//
// Build option
//   PARITY_RX_SYNC_EN  when defined, s_in passes through a 2-flop synchronizer
//                      (reset to 1), which delays every sample point by 2 clocks.

module parity_checker_rx #(
   parameter int unsigned DATA_W       = 4,
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter bit          PARITY_ODD   = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_in,
   output logic [DATA_W-1:0] d_out,
   output logic              valid,
   output logic              parity_err,
   output logic              frame_err
);

   localparam int unsigned HALF = CLKS_PER_BIT / 2;
   localparam int unsigned CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [CW-1:0] CYC_HALF = CW'(HALF - 1);
   localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   logic              line;
   logic [2:0]        state;
   logic [CW-1:0]     cyc_cnt;
   logic [BW-1:0]     bit_cnt;
   logic [DATA_W-1:0] shift_reg;
   logic              par_bit;

`ifdef PARITY_RX_SYNC_EN
   logic s_meta;
   logic s_sync;

   // Reset to the idle level so that leaving reset is not mistaken for a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_meta <= 1'b1;
         s_sync <= 1'b1;
      end else begin
         s_meta <= s_in;
         s_sync <= s_meta;
      end
   end

   assign line = s_sync;
`else
   assign line = s_in;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cyc_cnt    <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         par_bit    <= 1'b0;
         d_out      <= '0;
         valid      <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               cyc_cnt <= '0;
               if (!line) begin
                  state <= ST_START;
               end
            end
            ST_START: begin
               if (cyc_cnt == CYC_HALF) begin
                  cyc_cnt <= '0;
                  bit_cnt <= '0;
                  // A line already back high at mid-bit is a glitch; drop it silently.
                  state   <= line ? ST_IDLE : ST_DATA;
               end else begin
                  cyc_cnt <= cyc_cnt + CW'(1);
               end
            end
            ST_DATA: begin
               if (cyc_cnt == CYC_LAST) begin
                  cyc_cnt            <= '0;
                  shift_reg[bit_cnt] <= line;
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
                     state   <= ST_PARITY;
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end else begin
                  cyc_cnt <= cyc_cnt + CW'(1);
               end
            end
            ST_PARITY: begin
               if (cyc_cnt == CYC_LAST) begin
                  cyc_cnt <= '0;
                  par_bit <= line;
                  state   <= ST_STOP;
               end else begin
                  cyc_cnt <= cyc_cnt + CW'(1);
               end
            end
            ST_STOP: begin
               if (cyc_cnt == CYC_LAST) begin
                  cyc_cnt    <= '0;
                  state      <= ST_IDLE;
                  d_out      <= shift_reg;
                  parity_err <= ((^shift_reg) ^ PARITY_ODD) != par_bit;
                  frame_err  <= ~line;
                  valid      <= 1'b1;
               end else begin
                  cyc_cnt <= cyc_cnt + CW'(1);
               end
            end
            default: begin
               state   <= ST_IDLE;
               cyc_cnt <= '0;
               bit_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_parity_checker_rx.sv
// tb_parity_checker_rx
//   Directed bench for parity_checker_rx with default parameters (4 data bits,
//   4 clocks per bit, even parity). Serial bits are driven on falling edges;
//   a monitor logs every valid pulse with its cycle number and the outputs.

module tb_parity_checker_rx;

   localparam int CPB = 4;
`ifdef PARITY_RX_SYNC_EN
   localparam int LAT = 28;
`else
   localparam int LAT = 26;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       s_in;
   logic [3:0] d_out;
   logic       valid;
   logic       parity_err;
   logic       frame_err;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // valid-pulse log, indexed by pulse number modulo 16
   int         vcount = 0;
   int         vc_arr [16];
   logic [3:0] vd_arr [16];
   logic       vp_arr [16];
   logic       vf_arr [16];

   parity_checker_rx #(
      .DATA_W      (4),
      .CLKS_PER_BIT(CPB),
      .PARITY_ODD  (1'b0)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_in      (s_in),
      .d_out     (d_out),
      .valid     (valid),
      .parity_err(parity_err),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid === 1'b1) begin
         vc_arr[vcount % 16] <= cyc;
         vd_arr[vcount % 16] <= d_out;
         vp_arr[vcount % 16] <= parity_err;
         vf_arr[vcount % 16] <= frame_err;
         vcount              <= vcount + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input logic b);
      s_in = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic idle(input int n);
      s_in = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // e0 is the cycle index of the first rising edge that sees the start bit
   task automatic send_frame(input logic [3:0] d, input logic p, input logic st, output int e0);
      e0 = cyc + 1;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(d[i]);
      drive_bit(p);
      drive_bit(st);
   endtask

   initial begin
      int e0a, e0b, base;

      rst_n = 1'b0;
      s_in  = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_d_out", 32'(d_out), 32'h0);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_perr",  32'(parity_err), 32'h0);
      chk("rst_ferr",  32'(frame_err), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(4);

      // good frame 0011, parity 0
      base = vcount;
      send_frame(4'b0011, 1'b0, 1'b1, e0a);
      idle(6);
      chk("f1_count",   32'(vcount - base), 32'd1);
      chk("f1_latency", 32'(vc_arr[base % 16] - e0a), 32'(LAT));
      chk("f1_d_out",   32'(vd_arr[base % 16]), 32'h3);
      chk("f1_perr",    32'(vp_arr[base % 16]), 32'h0);
      chk("f1_ferr",    32'(vf_arr[base % 16]), 32'h0);
      chk("f1_valid_low", 32'(valid), 32'h0);

      // back-to-back 1011/p1 then 1111/p0
      base = vcount;
      send_frame(4'b1011, 1'b1, 1'b1, e0a);
      send_frame(4'b1111, 1'b0, 1'b1, e0b);
      idle(6);
      chk("b2b_count",   32'(vcount - base), 32'd2);
      chk("b2b_lat_a",   32'(vc_arr[base % 16] - e0a), 32'(LAT));
      chk("b2b_spacing", 32'(vc_arr[(base + 1) % 16] - vc_arr[base % 16]), 32'd28);
      chk("b2b_d_a",     32'(vd_arr[base % 16]), 32'hB);
      chk("b2b_d_b",     32'(vd_arr[(base + 1) % 16]), 32'hF);
      chk("b2b_perr_a",  32'(vp_arr[base % 16]), 32'h0);
      chk("b2b_perr_b",  32'(vp_arr[(base + 1) % 16]), 32'h0);
      chk("b2b_ferr_b",  32'(vf_arr[(base + 1) % 16]), 32'h0);

      // parity error: 1011 needs parity 1, send 0
      base = vcount;
      send_frame(4'b1011, 1'b0, 1'b1, e0a);
      idle(6);
      chk("pe_count", 32'(vcount - base), 32'd1);
      chk("pe_d_out", 32'(d_out), 32'hB);
      chk("pe_perr",  32'(parity_err), 32'h1);
      chk("pe_ferr",  32'(frame_err), 32'h0);

      // next good frame clears the sticky parity flag
      base = vcount;
      send_frame(4'b1111, 1'b0, 1'b1, e0a);
      idle(6);
      chk("pe_clr_count", 32'(vcount - base), 32'd1);
      chk("pe_clr_d_out", 32'(d_out), 32'hF);
      chk("pe_clr_perr",  32'(parity_err), 32'h0);

      // frame error: stop bit 0
      base = vcount;
      send_frame(4'b0101, 1'b0, 1'b0, e0a);
      idle(12);
      chk("fe_count", 32'(vcount - base), 32'd1);
      chk("fe_d_out", 32'(d_out), 32'h5);
      chk("fe_perr",  32'(parity_err), 32'h0);
      chk("fe_ferr",  32'(frame_err), 32'h1);

      // one-cycle glitch low: rejected at start check, outputs unchanged
      base = vcount;
      s_in = 1'b0;
      @(negedge clk);
      idle(40);
      chk("gl_count", 32'(vcount - base), 32'd0);
      chk("gl_d_out", 32'(d_out), 32'h5);
      chk("gl_ferr",  32'(frame_err), 32'h1);

      // reset during DATA of a 1111 frame
      base = vcount;
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      rst_n = 1'b0;
      #1;
      chk("mr_d_out", 32'(d_out), 32'h0);
      chk("mr_valid", 32'(valid), 32'h0);
      chk("mr_perr",  32'(parity_err), 32'h0);
      chk("mr_ferr",  32'(frame_err), 32'h0);
      s_in = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      idle(40);
      chk("mr_no_valid", 32'(vcount - base), 32'd0);

      base = vcount;
      send_frame(4'b0011, 1'b0, 1'b1, e0a);
      idle(6);
      chk("mr_f_count",   32'(vcount - base), 32'd1);
      chk("mr_f_latency", 32'(vc_arr[base % 16] - e0a), 32'(LAT));
      chk("mr_f_d_out",   32'(d_out), 32'h3);
      chk("mr_f_perr",    32'(parity_err), 32'h0);
      chk("mr_f_ferr",    32'(frame_err), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/parity_checker_rx.md
# parity_checker_rx

Serial receiver and checker for the 4-bit data plus parity word produced by `parity_generator`. It samples a framed serial line (start bit, DATA_W data bits LSB first, one parity bit, stop bit) at mid-bit and recomputes parity over the received data. It presents the word on `d_out` with a one-cycle `valid` strobe and sticky-until-next-frame error flags. It sits at the receiving end of the link and feeds downstream consumers that need the data word and its integrity status.

## Interface
- DATA_W, 4, data bits per frame.
- CLKS_PER_BIT, 4, clock cycles per serial bit; even, >= 2. HALF = CLKS_PER_BIT/2.
- PARITY_ODD, 0, 0 = even parity (parity bit = XOR of data, matches `parity_generator`), 1 = odd parity.

- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- s_in  input  1  serial line; idle high.
- d_out  output  DATA_W  last received data word.
- valid  output  1  one-cycle strobe: d_out and flags updated.
- parity_err  output  1  received parity bit mismatched recomputed parity for the frame in d_out.
- frame_err  output  1  stop bit sampled 0 for the frame in d_out.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP. A bit counter (0..DATA_W-1) and a cycle counter (0..CLKS_PER_BIT-1) run alongside it.
- Reset state:
  - FSM in IDLE, both counters at 0, shift register at 0.
  - d_out=0, valid=0, parity_err=0, frame_err=0.
  - Synchronizer flops (if compiled in) at 1.
- IDLE: when the line sample is 0, go to START with cycle counter cleared.
- START:
  - At cycle counter = HALF-1, sample the line.
  - If 1 (glitch or false start), return to IDLE; nothing is reported.
  - If 0, go to DATA with cycle and bit counters cleared.
- DATA:
  - At cycle counter = CLKS_PER_BIT-1, shift the sample into bit [bit counter] (LSB first) and clear the cycle counter.
  - After bit DATA_W-1, go to PARITY.
- PARITY: at cycle counter = CLKS_PER_BIT-1, capture the parity bit and go to STOP.
- STOP: at cycle counter = CLKS_PER_BIT-1, sample the stop bit and return to IDLE. On that same edge, register:
  - d_out = data
  - parity_err = (^data ^ PARITY_ODD) != parity bit
  - frame_err = ~stop
  - valid = 1
- valid deasserts on the next edge. d_out and both flags hold until the next completed frame.
- A frame with an error still updates d_out and pulses valid.
- A new start bit is detected on the first cycle after STOP returns to IDLE, so back-to-back frames are supported.
- Asynchronous reset mid-frame discards the partial frame. All outputs return to their reset values immediately.

## Timing
- Let E0 be the edge at which IDLE sees a 0 sample.
  - Start is checked at E0+HALF.
  - Data bit k is sampled at E0+HALF+(k+1)·CLKS_PER_BIT.
  - The parity bit is sampled at E0+HALF+(DATA_W+1)·CLKS_PER_BIT.
  - The stop bit is sampled at E0+HALF+(DATA_W+2)·CLKS_PER_BIT.
- valid is high for exactly the cycle following the stop-sample edge.
- With defaults: frame = 7 bits = 28 clocks, and valid rises 26 cycles after E0.
- Without the synchronizer, the sample is s_in directly and E0 is the first edge with s_in=0.

## Configuration
- Macro: `PARITY_RX_SYNC_EN`.
- Defined:
  - s_in passes through a 2-flop synchronizer (reset to 1) before the FSM.
  - All sample points and valid shift 2 cycles later relative to s_in.
- Undefined:
  - The FSM samples s_in directly, and s_in must already be synchronous to clk.
  - No other behavioural difference.

## Test plan
Defaults, even parity, no sync. Serial bits are given start, d0..d3, parity, stop, each 4 clocks.
- Send 4'b0011 with parity 0, stop 1 -> one valid pulse, d_out=4'b0011, parity_err=0, frame_err=0, valid 26 cycles after the start edge.
- Send 4'b1011 with parity 1, then immediately 4'b1111 with parity 0, no idle gap -> two valid pulses 28 cycles apart, d_out=4'b1011 then 4'b1111, no errors.
- Send 4'b1011 with parity 0 -> valid, d_out=4'b1011, parity_err=1, frame_err=0. The next good frame clears parity_err.
- Send 4'b0101 with parity 0, stop 0 -> valid, d_out=4'b0101, frame_err=1, parity_err=0.
- Drive s_in low for 1 cycle only, then high -> FSM returns to IDLE at the start check, no valid pulse, outputs unchanged.
- Assert rst_n=0 during DATA of a 4'b1111 frame, release, then send 4'b0011 with parity 0 -> outputs are 0 during reset, no valid for the aborted frame, then d_out=4'b0011 with no errors. Repeat with `PARITY_RX_SYNC_EN` defined and check the 2-cycle shift.
